// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the instruction fetch front end.
package pipeline_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;

    localparam logic [PC_W-1:0] PC_STEP          = PC_W'(4);
    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2
    } pfq_state_t;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return addr & ~PC_W'(3);
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// DEPTH-entry synchronous FIFO of {instruction, next-PC}; the caller owns all flow control.
module prefetch_fifo
    import pipeline_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [INSTR_W-1:0]     push_instr,
    input  logic [PC_W-1:0]        push_npc,
    output logic [$clog2(DEPTH):0] count,
    output logic [INSTR_W-1:0]     head_instr,
    output logic [PC_W-1:0]        head_npc
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]     rd_ptr_q;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W:0]       count_q;
    logic [INSTR_W-1:0]   instr_mem [DEPTH];
    logic [PC_W-1:0]      npc_mem   [DEPTH];

    // Storage is reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_mem[i] <= '0;
                npc_mem[i]   <= '0;
            end
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                instr_mem[wr_ptr_q] <= push_instr;
                npc_mem[wr_ptr_q]   <= push_npc;
                wr_ptr_q            <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign count      = count_q;
    assign head_instr = instr_mem[rd_ptr_q];
    assign head_npc   = npc_mem[rd_ptr_q];

endmodule

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetcher with credit-based issue and branch redirect/flush.
// Optional combinational bypass of an empty queue when PREFETCH_BYPASS_EN is defined.
module instr_prefetch_queue
    import pipeline_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               EX_MEM_PCSrc,
    input  logic [PC_W-1:0]    EX_MEM_NPC,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_npc,
    input  logic               out_ready
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned CRD_W = CNT_W + 1;

    pfq_state_t        state_q;
    logic              imem_req_q;
    logic [PC_W-1:0]   imem_addr_q;
    logic [PC_W-1:0]   fetch_pc_q;
    logic              rsp_pending_q;
    logic [PC_W-1:0]   rsp_addr_q;

    logic [CNT_W-1:0]   fifo_count;
    logic [INSTR_W-1:0] head_instr;
    logic [PC_W-1:0]    head_npc;
    logic               fifo_empty;
    logic               rsp_live;
    logic               byp_take;
    logic               push;
    logic               pop;
    logic [CRD_W-1:0]   credit_need;
    logic               issue;
    logic [PC_W-1:0]    redirect_pc;
    logic [PC_W-1:0]    rsp_npc;

    assign fifo_empty  = (fifo_count == '0);
    assign rsp_live    = rsp_pending_q && (state_q != KILL);
    assign redirect_pc = word_align(EX_MEM_NPC);
    assign rsp_npc     = rsp_addr_q + PC_STEP;

`ifdef PREFETCH_BYPASS_EN
    logic byp_valid;

    assign byp_valid = rsp_live && fifo_empty;

    always_comb begin
        out_valid = !fifo_empty || byp_valid;
        out_instr = byp_valid ? imem_rdata : head_instr;
        out_npc   = byp_valid ? rsp_npc : head_npc;
    end

    assign byp_take = byp_valid && out_ready;
`else
    always_comb begin
        out_valid = !fifo_empty;
        out_instr = head_instr;
        out_npc   = head_npc;
    end

    assign byp_take = 1'b0;
`endif

    assign pop  = !fifo_empty && out_ready;
    // A redirect wins over the response arriving this cycle; a bypassed word is already consumed.
    assign push = rsp_live && !EX_MEM_PCSrc && !byp_take;

    // Occupancy after this edge, plus the outstanding request, plus the one we would issue.
    assign credit_need = CRD_W'(fifo_count) + CRD_W'(push) - CRD_W'(pop)
                       + CRD_W'(imem_req_q) + CRD_W'(1);
    assign issue       = credit_need <= CRD_W'(DEPTH);

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .flush      (EX_MEM_PCSrc),
        .push_instr (imem_rdata),
        .push_npc   (rsp_npc),
        .count      (fifo_count),
        .head_instr (head_instr),
        .head_npc   (head_npc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FILL;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= RESET_PC;
            fetch_pc_q    <= RESET_PC;
            rsp_pending_q <= 1'b0;
            rsp_addr_q    <= RESET_PC;
        end else begin
            rsp_pending_q <= imem_req_q;
            rsp_addr_q    <= imem_addr_q;
            if (EX_MEM_PCSrc) begin
                imem_req_q  <= 1'b1;
                imem_addr_q <= redirect_pc;
                fetch_pc_q  <= redirect_pc + PC_STEP;
                // The response to this cycle's request lands next cycle and must be dropped.
                state_q     <= imem_req_q ? KILL : FILL;
            end else if (issue) begin
                imem_req_q  <= 1'b1;
                imem_addr_q <= fetch_pc_q;
                fetch_pc_q  <= fetch_pc_q + PC_STEP;
                state_q     <= FILL;
            end else begin
                imem_req_q  <= 1'b0;
                state_q     <= WAIT;
            end
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench: transaction-level queue model plus directed and random stimulus.
module tb_instr_prefetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        EX_MEM_PCSrc;
    logic [31:0] EX_MEM_NPC;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_npc;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .EX_MEM_PCSrc (EX_MEM_PCSrc),
        .EX_MEM_NPC   (EX_MEM_NPC),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .out_valid    (out_valid),
        .out_instr    (out_instr),
        .out_npc      (out_npc),
        .out_ready    (out_ready)
    );

    // Instruction memory: word at address A holds A/4, returned one cycle after the request.
    logic        mem_v;
    logic [31:0] mem_a;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_v <= 1'b0;
            mem_a <= 32'h0;
        end else begin
            mem_v <= imem_req;
            mem_a <= imem_addr;
        end
    end
    assign imem_rdata = mem_v ? (mem_a >> 2) : 32'hDEAD_BEEF;

    // Reference model: a queue of delivered words and the single in-flight response.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] npc;
    } ent_t;

    ent_t        q[$];
    logic        m_req;
    logic [31:0] m_addr;
    logic [31:0] m_pc;
    logic        inf_v;
    logic        inf_dead;
    logic [31:0] inf_addr;

    task automatic model_reset();
        q.delete();
        m_req    = 1'b0;
        m_addr   = RESET_PC;
        m_pc     = RESET_PC;
        inf_v    = 1'b0;
        inf_dead = 1'b0;
        inf_addr = 32'h0;
    endtask

    task automatic model_step();
        logic        nv;
        logic [31:0] na;
        logic        ndead;
        ent_t        e;
        if (!rst_n) begin
            model_reset();
            return;
        end
        nv    = m_req;
        na    = m_addr;
        ndead = 1'b0;
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (EX_MEM_PCSrc) begin
            q.delete();
            ndead  = m_req;
            m_req  = 1'b1;
            m_addr = {EX_MEM_NPC[31:2], 2'b00};
            m_pc   = m_addr + 32'd4;
        end else begin
            if (inf_v && !inf_dead) begin
                e.instr = inf_addr >> 2;
                e.npc   = inf_addr + 32'd4;
                q.push_back(e);
            end
            if (q.size() + int'(m_req) + 1 <= int'(DEPTH)) begin
                m_req  = 1'b1;
                m_addr = m_pc;
                m_pc   = m_pc + 32'd4;
            end else begin
                m_req = 1'b0;
            end
        end
        inf_v    = nv;
        inf_addr = na;
        inf_dead = ndead;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("imem_req", 32'(imem_req), 32'(m_req));
        if (m_req) chk("imem_addr", imem_addr, m_addr);
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_instr", out_instr, q[0].instr);
            chk("out_npc", out_npc, q[0].npc);
        end
    endtask

    // Apply inputs, step the model at the edge, compare on the following falling edge.
    task automatic tick(input logic rdy, input logic sel, input logic [31:0] tgt);
        out_ready    = rdy;
        EX_MEM_PCSrc = sel;
        EX_MEM_NPC   = tgt;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, 32'(imem_req), 32'h0);
        chk({tag, "_addr"}, imem_addr, RESET_PC);
        chk({tag, "_valid"}, 32'(out_valid), 32'h0);
        chk({tag, "_instr"}, out_instr, 32'h0);
        chk({tag, "_npc"}, out_npc, 32'h0);
    endtask

    int          nreq;
    logic [31:0] tgt;

    initial begin
        rst_n        = 1'b0;
        out_ready    = 1'b0;
        EX_MEM_PCSrc = 1'b0;
        EX_MEM_NPC   = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset_outputs("por");

        // Steady stream from reset
        rst_n = 1'b1;
        tick(1'b1, 1'b0, 32'h0);
        chk("c1_req", 32'(imem_req), 32'h1);
        chk("c1_addr", imem_addr, 32'h0);
        tick(1'b1, 1'b0, 32'h0);
        chk("c2_addr", imem_addr, 32'h4);
        tick(1'b1, 1'b0, 32'h0);
        chk("c3_valid", 32'(out_valid), 32'h1);
        chk("c3_instr", out_instr, 32'h0);
        chk("c3_npc", out_npc, 32'h4);
        tick(1'b1, 1'b0, 32'h0);
        chk("c4_instr", out_instr, 32'h1);
        repeat (4) tick(1'b1, 1'b0, 32'h0);

        // Redirect mid-stream
        tick(1'b1, 1'b1, 32'h0000_0100);
        chk("rd_addr", imem_addr, 32'h0000_0100);
        tick(1'b1, 1'b0, 32'h0);
        chk("rd_stale", 32'(out_valid), 32'h0);
        tick(1'b1, 1'b0, 32'h0);
        chk("rd_npc", out_npc, 32'h0000_0104);
        repeat (3) tick(1'b1, 1'b0, 32'h0);

        // Redirect coinciding with a pop
        chk("rp_pre_valid", 32'(out_valid), 32'h1);
        tick(1'b1, 1'b1, 32'h0000_0200);
        chk("rp_empty", 32'(out_valid), 32'h0);
        repeat (2) tick(1'b0, 1'b0, 32'h0);
        chk("rp_target", out_npc, 32'h0000_0204);
        repeat (3) tick(1'b1, 1'b0, 32'h0);

        // Redirect to the top word; fetch wraps to zero
        tick(1'b1, 1'b1, 32'hFFFF_FFFF);
        chk("wr_addr0", imem_addr, 32'hFFFF_FFFC);
        tick(1'b1, 1'b0, 32'h0);
        chk("wr_addr1", imem_addr, 32'h0);
        tick(1'b1, 1'b0, 32'h0);
        chk("wr_npc", out_npc, 32'h0);
        chk("wr_instr", out_instr, 32'h3FFF_FFFF);

        // Asynchronous reset with the queue filling and a request outstanding
        repeat (3) tick(1'b0, 1'b0, 32'h0);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("async");
        model_reset();
        repeat (2) tick(1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;

        // Backpressure: credit allows exactly DEPTH requests
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, 32'h0);
            if (imem_req) nreq++;
            if (i == 0) chk("bp_restart", imem_addr, RESET_PC);
        end
        chk("bp_nreq", 32'(nreq), 32'(DEPTH));
        chk("bp_head", out_npc, 32'h4);
        for (int i = 0; i < 4; i++) begin
            chk("bp_order", out_npc, 32'(4 * (i + 1)));
            tick(1'b1, 1'b0, 32'h0);
        end

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            tgt = $urandom();
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, tgt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
